// File: rtl/am_insert_tx.sv
// am_insert_tx -- periodic alignment-marker insertion for one lane of a
// 64b/66b transmit path.
//
// A slot counter walks 0..GAP_N. Slot 0 emits the lane's alignment marker
// unconditionally (upstream is stalled via ready_o). Slots 1..GAP_N pass
// upstream blocks through with one cycle of latency. An 8-bit bit-interleaved
// parity (BIP) accumulates over every emitted block, and each marker carries
// the running value (BIP3) and its complement (BIP7).

module am_insert_tx #(
    parameter int BLOCK_W = 66,
    parameter int LANE    = 0,
    parameter int GAP_N   = 16383
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               valid_i,
    input  logic [BLOCK_W-1:0] block_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [BLOCK_W-1:0] block_o,
    output logic               am_v_o
);

    localparam int CNT_W = $clog2(GAP_N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GAP_N);
    localparam logic [CNT_W-1:0] CNT_FIRST_DATA = CNT_W'(1);

    // Fixed marker bytes packed as {M6, M5, M4, M2, M1, M0}.
    localparam logic [47:0] AM_LANE =
        (LANE == 1) ? 48'h193B0F_E6C4F0 :
        (LANE == 2) ? 48'h649A3A_9B65C5 :
        (LANE == 3) ? 48'hC2865D_3D79A2 :
                      48'hB8896F_477690;

    logic [CNT_W-1:0]   cnt;
    logic [7:0]         bip_acc;
    logic [BLOCK_W-1:0] am_block;

    // Parity contribution of one block: payload bit 2+8k+j folds into BIP bit
    // j, and the two sync-header bits fold into BIP bits 3 and 4.
    function automatic logic [7:0] block_bip(input logic [BLOCK_W-1:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            p = p ^ b[2 + 8*k +: 8];
        end
        p[3] = p[3] ^ b[0];
        p[4] = p[4] ^ b[1];
        return p;
    endfunction

    // Marker for the current slot: BIP3 is the accumulator as it stands,
    // BIP7 its complement, control sync header 2'b10.
    always_comb begin
        am_block = {~bip_acc, AM_LANE[47:24], bip_acc, AM_LANE[23:0], 2'b10};
    end

    // Upstream may only advance in data slots.
    assign ready_o = (cnt != '0);

    // Slot sequencing, output register and BIP accumulation.
    // NOTE: every register here, block_o included, is cleared by the async
    // reset so outputs read as zero while nreset is low; all updates use
    // non-blocking assignments so the accumulator and counter see the
    // pre-edge values of each other.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt     <= '0;
            bip_acc <= 8'h00;
            valid_o <= 1'b0;
            am_v_o  <= 1'b0;
            block_o <= '0;
        end else if (cnt == '0) begin
            // Marker slot: emit marker, restart parity from the marker itself.
            block_o <= am_block;
            valid_o <= 1'b1;
            am_v_o  <= 1'b1;
            bip_acc <= block_bip(am_block);
            cnt     <= (GAP_N == 0) ? '0 : CNT_FIRST_DATA;
        end else if (valid_i) begin
            // Data slot with an accepted block: pass through unmodified.
            block_o <= block_i;
            valid_o <= 1'b1;
            am_v_o  <= 1'b0;
            bip_acc <= bip_acc ^ block_bip(block_i);
            cnt     <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end else begin
            // Data slot without input: bubble, counter and parity hold.
            valid_o <= 1'b0;
            am_v_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_am_insert_tx.sv
// Testbench for am_insert_tx. Four instances share one stimulus stream:
// lane 0 with the full 16383-block gap, lanes 1..3 with a short gap so many
// marker periods pass. Per instance, a generator pushes the expected output of
// each clock edge into a queue and a monitor pops and compares on the
// following falling edge. Lane 0 additionally gets hand-computed marker checks.

module tb_am_insert_tx;

    logic        clk;
    logic        nreset;
    logic        valid_i;
    logic [65:0] block_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Hand-computed lane-0 markers: after reset (BIP3=00) and after a full
    // period of {64'h0, 2'b01} blocks (BIP3=18).
    localparam logic [65:0] AM0_RESET = {64'hFFB8896F00477690, 2'b10};
    localparam logic [65:0] AM0_FULL  = {64'hE7B8896F18477690, 2'b10};
    localparam logic [65:0] DATA_CONST = {64'h0, 2'b01};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference BIP, written bit by bit.
    function automatic logic [7:0] ref_bip(input logic [65:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int j = 0; j < 8; j++) begin
            for (int k = 0; k < 8; k++) begin
                p[j] = p[j] ^ b[2 + 8*k + j];
            end
        end
        p[3] = p[3] ^ b[0];
        p[4] = p[4] ^ b[1];
        return p;
    endfunction

    // Reference marker from the lane byte table.
    function automatic logic [65:0] ref_am(input int lane, input logic [7:0] bip);
        logic [7:0] m0, m1, m2, m4, m5, m6;
        case (lane)
            1:       begin m0 = 8'hF0; m1 = 8'hC4; m2 = 8'hE6; m4 = 8'h0F; m5 = 8'h3B; m6 = 8'h19; end
            2:       begin m0 = 8'hC5; m1 = 8'h65; m2 = 8'h9B; m4 = 8'h3A; m5 = 8'h9A; m6 = 8'h64; end
            3:       begin m0 = 8'hA2; m1 = 8'h79; m2 = 8'h3D; m4 = 8'h5D; m5 = 8'h86; m6 = 8'hC2; end
            default: begin m0 = 8'h90; m1 = 8'h76; m2 = 8'h47; m4 = 8'h6F; m5 = 8'h89; m6 = 8'hB8; end
        endcase
        return {~bip, m6, m5, m4, bip, m2, m1, m0, 2'b10};
    endfunction

    for (genvar l = 0; l < 4; l++) begin : g
        localparam int G = (l == 0) ? 16383 : 37;

        logic        ready;
        logic        vo;
        logic        amv;
        logic [65:0] bo;

        am_insert_tx #(
            .BLOCK_W(66),
            .LANE   (l),
            .GAP_N  (G)
        ) dut (
            .clk    (clk),
            .nreset (nreset),
            .valid_i(valid_i),
            .block_i(block_i),
            .ready_o(ready),
            .valid_o(vo),
            .block_o(bo),
            .am_v_o (amv)
        );

        logic [66:0] exp_q[$];
        int          m_cnt = 0;
        logic [7:0]  m_acc = 8'h00;
        int          n_mk  = 0;

        // Generator: on each rising edge, predict what that edge produces.
        initial begin
            logic [65:0] am;
            forever begin
                @(posedge clk);
                if (!nreset) begin
                    m_cnt = 0;
                    m_acc = 8'h00;
                    exp_q.delete();
                end else if (m_cnt == 0) begin
                    am = ref_am(l, m_acc);
                    exp_q.push_back({1'b1, am});
                    m_acc = ref_bip(am);
                    m_cnt = 1;
                end else if (valid_i) begin
                    exp_q.push_back({1'b0, block_i});
                    m_acc = m_acc ^ ref_bip(block_i);
                    m_cnt = (m_cnt == G) ? 0 : m_cnt + 1;
                end
            end
        end

        // Monitor: compare the registered outputs of the previous edge.
        initial begin
            logic [66:0] e;
            forever begin
                @(negedge clk);
                if (!nreset) begin
                    exp_q.delete();
                    check($sformatf("lane%0d_reset_outputs", l), {ready, vo, amv, bo}, 69'h0);
                end else begin
                    check($sformatf("lane%0d_ready", l), ready, (m_cnt != 0));
                    if (exp_q.size() == 0) begin
                        check($sformatf("lane%0d_idle_valid_am", l), {vo, amv}, 2'b00);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("lane%0d_valid", l), vo, 1'b1);
                        if (vo) begin
                            check($sformatf("lane%0d_block_am", l), {amv, bo}, e);
                            if (amv) n_mk++;
                        end
                    end
                end
            end
        end
    end

    // Wait until lane 0 has shown `target` markers; sample just after the
    // falling edge so the monitor has already counted it.
    task automatic wait_marker0(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (g[0].n_mk >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int rl;
        int cyc_m2;
        int cyc_m3;

        nreset  = 1'b0;
        valid_i = 1'b0;
        block_i = '0;
        cyc_m2  = 0;
        cyc_m3  = 0;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("reset_ready_valid_am", {g[0].ready, g[0].vo, g[0].amv}, 3'b000);
        check("reset_block", g[0].bo, 66'h0);

        // Release reset, stream constant blocks continuously.
        @(posedge clk);
        #1;
        nreset  = 1'b1;
        valid_i = 1'b1;
        block_i = DATA_CONST;

        fork
            begin
                rl = 0;
                for (int i = 0; i < 16384; i++) begin
                    @(negedge clk);
                    if (!g[0].ready) rl++;
                end
                check("ready_low_cycles_per_period", rl, 1);
            end
            begin
                wait_marker0(1, 10, ok);
                check("first_marker_seen", ok, 1'b1);
                check("first_marker_block_am", {g[0].amv, g[0].bo}, {1'b1, AM0_RESET});
                wait_marker0(2, 16400, ok);
                check("second_marker_seen", ok, 1'b1);
                check("second_marker_block_am", {g[0].amv, g[0].bo}, {1'b1, AM0_FULL});
                cyc_m2 = cyc;
            end
        join

        // 100-cycle input gap mid-period: marker slips by exactly 100 cycles,
        // BIP unchanged.
        repeat (5000) @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        valid_i = 1'b1;
        wait_marker0(3, 12000, ok);
        check("third_marker_seen", ok, 1'b1);
        check("third_marker_block_am", {g[0].amv, g[0].bo}, {1'b1, AM0_FULL});
        cyc_m3 = cyc;
        check("third_marker_spacing", cyc_m3 - cyc_m2, 16384 + 100);

        // Random data with occasional bubbles until lane 0's fourth marker.
        ok = 1'b0;
        for (int i = 0; i < 25000; i++) begin
            @(posedge clk);
            #1;
            valid_i = ($urandom_range(0, 9) != 0);
            block_i = {$urandom(), $urandom(), 2'($urandom())};
            if (g[0].n_mk >= 4) begin
                ok = 1'b1;
                break;
            end
        end
        check("fourth_marker_seen", ok, 1'b1);

        // Continuous random data until lane 0 sits at slot 5000, then reset.
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            #1;
            if (g[0].m_cnt == 5000) begin
                ok = 1'b1;
                break;
            end
            valid_i = 1'b1;
            block_i = {$urandom(), $urandom(), 2'($urandom())};
        end
        check("reached_slot_5000", ok, 1'b1);
        nreset = 1'b0;
        #1;
        check("midgap_reset_immediate", {g[0].ready, g[0].vo, g[0].amv, g[0].bo}, 69'h0);

        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
        @(negedge clk);
        check("post_reset_marker_slot_ready", g[0].ready, 1'b0);
        @(negedge clk);
        #1;
        check("post_reset_first_block", {g[0].vo, g[0].amv, g[0].bo}, {2'b11, AM0_RESET});

        // A little more traffic, then confirm short-gap lanes cycled markers.
        repeat (200) begin
            @(posedge clk);
            #1;
            block_i = {$urandom(), $urandom(), 2'($urandom())};
        end
        check("lane1_markers_seen", (g[1].n_mk >= 3), 1'b1);
        check("lane2_markers_seen", (g[2].n_mk >= 3), 1'b1);
        check("lane3_markers_seen", (g[3].n_mk >= 3), 1'b1);

        valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/am_insert_tx.md
AM_INSERT_TX -- requirements
Module: am_insert_tx

Interface
REQ-001 SHALL have parameter BLOCK_W, default 66, meaning block width: 2-bit sync header in [1:0] and 64-bit payload in [65:2].
REQ-002 SHALL have parameter LANE, default 0, range 0..3, meaning the lane whose alignment marker is inserted.
REQ-003 SHALL have parameter GAP_N, default 16383, meaning the number of data blocks between consecutive markers.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 nreset  input  1  asynchronous active-low reset.
REQ-006 valid_i  input  1  block_i holds a valid block.
REQ-007 block_i  input  BLOCK_W  scrambled 66-bit block from upstream, {data, head}.
REQ-008 ready_o  output  1  upstream block accepted this cycle when valid_i=1; combinational from state.
REQ-009 valid_o  output  1  block_o valid, registered.
REQ-010 block_o  output  BLOCK_W  data block or alignment marker, registered.
REQ-011 am_v_o  output  1  block_o currently holds an alignment marker.

Function
REQ-012 SHALL keep a slot counter cnt, range 0..GAP_N; cnt=0 is the marker slot and cnt=1..GAP_N are data slots.
REQ-013 SHALL drive ready_o = (cnt != 0) when out of reset.
REQ-014 In the marker slot, SHALL emit the marker on the next edge with valid_o=1 and am_v_o=1, regardless of valid_i, and set cnt to 1.
REQ-015 In a data slot with valid_i=1, SHALL register block_i to block_o with valid_o=1 and am_v_o=0, and advance cnt.
REQ-016 Counter advance SHALL wrap from GAP_N to 0.
REQ-017 In a data slot with valid_i=0, SHALL set valid_o=0, hold cnt and hold the BIP accumulator; block_o is don't-care.
REQ-018 Latency SHALL be 1 cycle from input acceptance to block_o.
REQ-019 Marker layout SHALL be:
- [1:0] = 2'b10
- [9:2] = M0, [17:10] = M1, [25:18] = M2
- [33:26] = BIP3
- [41:34] = M4, [49:42] = M5, [57:50] = M6
- [65:58] = BIP7 = ~BIP3
REQ-020 Marker bytes M0,M1,M2 / M4,M5,M6 SHALL be:
- lane 0: 90,76,47 / 6F,89,B8
- lane 1: F0,C4,E6 / 0F,3B,19
- lane 2: C5,65,9B / 3A,9A,64
- lane 3: A2,79,3D / 5D,86,C2
REQ-021 Each emitted block b SHALL XOR into an 8-bit BIP accumulator:
- bit j = b[2+j] ^ b[10+j] ^ … ^ b[58+j]
- additionally b[0] into bit 3 and b[1] into bit 4
REQ-022 BIP3 of a marker SHALL equal the accumulator value at the marker slot, covering all blocks since the previous marker, including that marker (with its BIP fields) and excluding the current one.
REQ-023 On emitting a marker, SHALL load the accumulator with the parity of that complete marker.
REQ-024 Data blocks SHALL pass through unmodified; the sync header is not checked.

Reset
REQ-025 While nreset=0, SHALL hold cnt=0, accumulator=0x00, valid_o=0, am_v_o=0, block_o=0 and ready_o=0.
REQ-026 The first cycle after reset release SHALL be a marker slot, producing BIP3=0x00 and BIP7=0xFF.
REQ-027 Reset asserted mid-gap SHALL take effect immediately, with no pending block emitted.

Verification
REQ-028 Reset release, LANE=0 -> first block_o = marker with bytes 90,76,47,00,6F,89,B8,FF, head 10, am_v_o=1; ready_o=0 in that slot.
REQ-029 Continuous valid_i=1 with block_i={64'h0,2'b01} -> exactly 16383 data outputs, then a marker with BIP3=0x18 and BIP7=0xE7; ready_o low exactly 1 cycle per 16384.
REQ-030 valid_i=0 for 100 cycles mid-gap -> valid_o=0 for those cycles; the next marker is delayed by exactly 100 cycles and its BIP is unchanged.
REQ-031 Random data, LANE=0..3 over 3 periods -> each marker matches REQ-020 and a bit-level reference BIP model; BIP7=~BIP3 always.
REQ-032 nreset pulsed low at cnt=5000 -> outputs zero immediately; after release the first block is a marker with BIP3=0x00.
REQ-033 Loopback into am_lock_rx with the matching lane -> lock_v_o asserts after the second marker, and lane_o[LANE]=1.
